// File: rtl/sr_flop_pkg.sv
// Shared definitions for the sr_flop_bank storage bank: mode encoding and the
// per-channel next-state rule used by every storage cell.
package sr_flop_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    typedef struct packed {
        logic q_next;
        logic illegal;
    } next_t;

    // Next state assumes the channel is enabled; the cell applies en separately.
    function automatic next_t next_state(
        input logic [1:0] mode,
        input logic       s,
        input logic       r,
        input logic       q,
        input logic       set_dominant
    );
        next_t ns;
        ns.q_next  = q;
        ns.illegal = 1'b0;
        case (mode)
            MODE_SR: begin
                case ({s, r})
                    2'b10:   ns.q_next = 1'b1;
                    2'b01:   ns.q_next = 1'b0;
                    2'b11: begin
                        if (set_dominant) begin
                            ns.q_next = 1'b1;
                        end else begin
                            ns.q_next  = q;
                            ns.illegal = 1'b1;
                        end
                    end
                    default: ns.q_next = q;
                endcase
            end
            MODE_JK: begin
                case ({s, r})
                    2'b10:   ns.q_next = 1'b1;
                    2'b01:   ns.q_next = 1'b0;
                    2'b11:   ns.q_next = ~q;
                    default: ns.q_next = q;
                endcase
            end
            MODE_D:  ns.q_next = s;
            MODE_T:  ns.q_next = s ? ~q : q;
            default: ns.q_next = q;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/sr_flop_cell.sv
// One storage channel: holds q and its sticky illegal-input flag.
// Reports the illegal event of the current cycle for the bank-level counter.
module sr_flop_cell
    import sr_flop_pkg::*;
#(
    parameter logic RESET_VAL    = 1'b0,
    parameter bit   SET_DOMINANT = 1'b0
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] mode_i,
    input  logic       en_i,
    input  logic       s_i,
    input  logic       r_i,
    input  logic       err_clear_i,
    output logic       q_o,
    output logic       err_o,
    output logic       illegal_o
);

    logic  q_q, q_d;
    logic  err_q, err_d;
    next_t ns;

    always_comb begin
        ns        = next_state(mode_i, s_i, r_i, q_q, SET_DOMINANT);
        illegal_o = en_i & ns.illegal;
        q_d       = en_i ? ns.q_next : q_q;
        // A new illegal event outranks a clear on the same edge.
        err_d     = (err_q & ~err_clear_i) | illegal_o;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            q_q   <= RESET_VAL;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    assign q_o   = q_q;
    assign err_o = err_q;

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of WIDTH clocked SR/JK/D/T storage cells with sticky illegal-input flags.
// Define SR_ERR_CNT_EN to add the saturating illegal-event counter err_count_o.
module sr_flop_bank
    import sr_flop_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter bit               SET_DOMINANT = 1'b0,
    parameter int               ERR_CNT_W    = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [1:0]           mode_i,
    input  logic [WIDTH-1:0]     en_i,
    input  logic [WIDTH-1:0]     s_i,
    input  logic [WIDTH-1:0]     r_i,
    input  logic                 err_clear_i,
    output logic [WIDTH-1:0]     q_o,
    output logic [WIDTH-1:0]     qbar_o,
    output logic [WIDTH-1:0]     err_o
`ifdef SR_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count_o
`endif
);

    logic [WIDTH-1:0] illegal;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_flop_cell #(
            .RESET_VAL    (RESET_VAL[i]),
            .SET_DOMINANT (SET_DOMINANT)
        ) u_cell (
            .clock_i     (clock_i),
            .reset_i     (reset_i),
            .mode_i      (mode_i),
            .en_i        (en_i[i]),
            .s_i         (s_i[i]),
            .r_i         (r_i[i]),
            .err_clear_i (err_clear_i),
            .q_o         (q_o[i]),
            .err_o       (err_o[i]),
            .illegal_o   (illegal[i])
        );
    end

    // qbar comes straight from the same register, so it can never equal q.
    assign qbar_o = ~q_o;

`ifdef SR_ERR_CNT_EN
    localparam int          POP_W   = $clog2(WIDTH + 1);
    localparam logic [31:0] CNT_MAX = (32'd1 << ERR_CNT_W) - 32'd1;

    logic [ERR_CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [POP_W-1:0]     pop;
    logic [31:0]          sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + POP_W'(illegal[i]);
        end
        cnt_base = err_clear_i ? '0 : cnt_q;
        sum      = 32'(cnt_base) + 32'(pop);
        if (sum > CNT_MAX) begin
            cnt_d = CNT_MAX[ERR_CNT_W-1:0];
        end else begin
            cnt_d = sum[ERR_CNT_W-1:0];
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count_o = cnt_q;
`else
    // Without the counter the per-cycle event vector has no consumer.
    logic unused_illegal;
    assign unused_illegal = ^illegal;
`endif

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench for sr_flop_bank; counter checks compile in only with SR_ERR_CNT_EN.
module tb_sr_flop_bank;

    logic       clk = 1'b0;
    logic       reset, err_clear;
    logic [1:0] mode;
    logic [7:0] en, s, r;
    logic [7:0] q, qbar, err;
    logic       sd_reset;
    logic [1:0] sd_mode;
    logic [7:0] sd_en, sd_s, sd_r;
    logic [7:0] sd_q, sd_qbar, sd_err;
`ifdef SR_ERR_CNT_EN
    logic [3:0] err_count;
    logic [7:0] sd_err_count;
`endif
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sr_flop_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SET_DOMINANT(1'b0), .ERR_CNT_W(4)) dut (
        .clock_i(clk), .reset_i(reset), .mode_i(mode), .en_i(en), .s_i(s), .r_i(r),
        .err_clear_i(err_clear), .q_o(q), .qbar_o(qbar), .err_o(err)
`ifdef SR_ERR_CNT_EN
        , .err_count_o(err_count)
`endif
    );

    sr_flop_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SET_DOMINANT(1'b1), .ERR_CNT_W(8)) dut_sd (
        .clock_i(clk), .reset_i(sd_reset), .mode_i(sd_mode), .en_i(sd_en), .s_i(sd_s), .r_i(sd_r),
        .err_clear_i(1'b0), .q_o(sd_q), .qbar_o(sd_qbar), .err_o(sd_err)
`ifdef SR_ERR_CNT_EN
        , .err_count_o(sd_err_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string name, input logic [7:0] exp_q);
        nvec++;
        if (q !== exp_q || qbar !== ~exp_q) begin
            nerr++;
            $display("FAIL %s: q=%h qbar=%h expected q=%h qbar=%h", name, q, qbar, exp_q, ~exp_q);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; err_clear = 1'b0; mode = 2'b00; en = 8'hFF; s = 8'hFF; r = 8'hFF;
        step(); step();
        chk_q("reset_q", 8'hA5);
        nvec++;
        if (err !== 8'h00) begin nerr++; $display("FAIL reset_err: got %h expected 00", err); end
`ifdef SR_ERR_CNT_EN
        nvec++;
        if (err_count !== 4'd0) begin nerr++; $display("FAIL reset_cnt: got %0d expected 0", err_count); end
`endif
        reset = 1'b0; s = 8'h00; r = 8'h00;
        step();
        chk_q("reset_release_hold", 8'hA5);
    endtask

    task automatic test_mode_change();
        mode = 2'b01; s = 8'h00; r = 8'h00;
        step();
        chk_q("mode_change_hold", 8'hA5);
        mode = 2'b00;
    endtask

    task automatic test_sr();
        s = 8'h0F; r = 8'hF0;
        step();
        chk_q("sr_set_clear", 8'h0F);
        s = 8'h01; r = 8'h01;
        step();
        chk_q("sr_illegal_hold", 8'h0F);
        nvec++;
        if (err !== 8'h01) begin nerr++; $display("FAIL sr_illegal_err: got %h expected 01", err); end
`ifdef SR_ERR_CNT_EN
        nvec++;
        if (err_count !== 4'd1) begin nerr++; $display("FAIL sr_illegal_cnt: got %0d expected 1", err_count); end
`endif
        err_clear = 1'b1; s = 8'h02; r = 8'h02;
        step();
        nvec++;
        if (err !== 8'h02) begin nerr++; $display("FAIL clear_vs_event_err: got %h expected 02", err); end
`ifdef SR_ERR_CNT_EN
        nvec++;
        if (err_count !== 4'd1) begin nerr++; $display("FAIL clear_vs_event_cnt: got %0d expected 1", err_count); end
`endif
        s = 8'h00; r = 8'h00;
        step();
        nvec++;
        if (err !== 8'h00) begin nerr++; $display("FAIL clear_err: got %h expected 00", err); end
        chk_q("clear_q_hold", 8'h0F);
        err_clear = 1'b0;
    endtask

    task automatic test_jk_t();
        mode = 2'b01; s = 8'hFF; r = 8'hFF;
        step();
        chk_q("jk_toggle1", 8'hF0);
        step();
        chk_q("jk_toggle2", 8'h0F);
        nvec++;
        if (err !== 8'h00) begin nerr++; $display("FAIL jk_no_err: got %h expected 00", err); end
        mode = 2'b11; s = 8'h81; r = 8'hFF;
        step();
        chk_q("t_toggle1", 8'h8E);
        step();
        chk_q("t_toggle2", 8'h0F);
    endtask

    task automatic test_enable();
        mode = 2'b10; en = 8'hFF; s = 8'h00; r = 8'h00;
        step();
        chk_q("d_load_zero", 8'h00);
        en = 8'h00; s = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_q("en_off_hold", 8'h00);
        end
        mode = 2'b00; r = 8'hFF;
        step();
        nvec++;
        if (err !== 8'h00) begin nerr++; $display("FAIL en_off_no_err: got %h expected 00", err); end
        mode = 2'b10; en = 8'h01; r = 8'h00;
        step();
        chk_q("en_bit0_only", 8'h01);
    endtask

    task automatic test_burst_reset();
        mode = 2'b00; en = 8'hFF; s = 8'hFF; r = 8'hFF;
        step();
        chk_q("burst_hold", 8'h01);
        nvec++;
        if (err !== 8'hFF) begin nerr++; $display("FAIL burst_err: got %h expected ff", err); end
`ifdef SR_ERR_CNT_EN
        nvec++;
        if (err_count !== 4'd8) begin nerr++; $display("FAIL burst_cnt1: got %0d expected 8", err_count); end
        step();
        nvec++;
        if (err_count !== 4'd15) begin nerr++; $display("FAIL burst_cnt_sat: got %0d expected 15", err_count); end
        step();
        nvec++;
        if (err_count !== 4'd15) begin nerr++; $display("FAIL burst_cnt_nowrap: got %0d expected 15", err_count); end
`endif
        reset = 1'b1; err_clear = 1'b0;
        step();
        chk_q("burst_reset_q", 8'hA5);
        nvec++;
        if (err !== 8'h00) begin nerr++; $display("FAIL burst_reset_err: got %h expected 00", err); end
`ifdef SR_ERR_CNT_EN
        nvec++;
        if (err_count !== 4'd0) begin nerr++; $display("FAIL burst_reset_cnt: got %0d expected 0", err_count); end
`endif
        reset = 1'b0; s = 8'h00; r = 8'h00;
        step();
    endtask

    task automatic test_set_dominant();
        sd_reset = 1'b1; sd_mode = 2'b00; sd_en = 8'hFF; sd_s = 8'h00; sd_r = 8'h00;
        step();
        sd_reset = 1'b0; sd_s = 8'h01; sd_r = 8'h01;
        step();
        nvec++;
        if (sd_q !== 8'h01 || sd_err !== 8'h00 || sd_qbar !== 8'hFE) begin
            nerr++;
            $display("FAIL setdom_bit0: q=%h err=%h qbar=%h expected q=01 err=00 qbar=fe", sd_q, sd_err, sd_qbar);
        end
        sd_s = 8'hFF; sd_r = 8'hFF;
        step();
        nvec++;
        if (sd_q !== 8'hFF || sd_err !== 8'h00) begin
            nerr++;
            $display("FAIL setdom_all: q=%h err=%h expected q=ff err=00", sd_q, sd_err);
        end
`ifdef SR_ERR_CNT_EN
        nvec++;
        if (sd_err_count !== 8'd0) begin nerr++; $display("FAIL setdom_cnt: got %0d expected 0", sd_err_count); end
`endif
    endtask

    initial begin
        sd_reset = 1'b1; sd_mode = 2'b00; sd_en = 8'h00; sd_s = 8'h00; sd_r = 8'h00;
        test_reset();
        test_mode_change();
        test_sr();
        test_jk_t();
        test_enable();
        test_burst_reset();
        test_set_dominant();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
